// File: rtl/mem_pkg.sv
// mem_pkg: shared MEM-stage types, default watchdog limit and writeback select encodings.
package mem_pkg;
    typedef enum logic {IDLE, ACCESS} mem_state_t;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_MEM = 2'd1;
    localparam logic [1:0] RS_LR  = 2'd2;
    localparam logic [1:0] RS_FL  = 2'd3;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts ACCESS cycles without ack and flags the cycle the limit is reached.
module mem_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    // expire fires in the ACCESS cycle whose increment would reach LIMIT
    assign expire = active && (cnt == W'(LIMIT - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (start) cnt <= '0;
        else if (active) cnt <= cnt + 1'b1;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with req/ack data memory handshake and MEM/WB register.
module memory_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ExMe_out_alu_out,
  input  logic [31:0] ExMe_out_reg_2,
  input  logic        ExMe_out_mem_en,
  input  logic        ExMe_out_mem_wrt,
  input  logic        ExMe_out_reg_wrt_en,
  input  logic [1:0]  ExMe_out_result_sel,
  input  logic [4:0]  ExMe_out_rd,
  input  logic [31:0] ExMe_out_LR,
  input  logic [1:0]  ExMe_out_FL,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic [31:0] MeWb_out_alu_out,
  output logic [31:0] MeWb_out_mem_data,
  output logic        MeWb_out_reg_wrt_en,
  output logic [1:0]  MeWb_out_result_sel,
  output logic [4:0]  MeWb_out_rd,
  output logic [31:0] MeWb_out_LR,
  output logic [1:0]  MeWb_out_FL
);
  mem_state_t state;
  logic misalign, mem_op, start, done, expire;
  assign misalign = ExMe_out_mem_en && (ExMe_out_alu_out[1:0] != 2'b00);
  assign mem_op = ExMe_out_mem_en && (ExMe_out_alu_out[1:0] == 2'b00);
  assign start = (state == IDLE) && mem_op;
  assign done = (state == ACCESS) && dmem_ack;
`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .active((state == ACCESS) && !dmem_ack),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  assign dmem_req = (state == ACCESS);
  assign mem_stall = start || ((state == ACCESS) && !dmem_ack && !expire);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      mem_misalign <= 1'b0;
      mem_fault <= 1'b0;
      MeWb_out_alu_out <= '0;
      MeWb_out_mem_data <= '0;
      MeWb_out_reg_wrt_en <= 1'b0;
      MeWb_out_result_sel <= '0;
      MeWb_out_rd <= '0;
      MeWb_out_LR <= '0;
      MeWb_out_FL <= '0;
    end else begin
      mem_misalign <= (state == IDLE) && misalign;
      mem_fault <= expire;
      if (start) begin
        state <= ACCESS;
        dmem_we <= ExMe_out_mem_wrt;
        dmem_addr <= ExMe_out_alu_out;
        dmem_wdata <= ExMe_out_reg_2;
      end else if (done || expire) state <= IDLE;
      if (mem_stall) MeWb_out_reg_wrt_en <= 1'b0;
      else begin
        MeWb_out_alu_out <= ExMe_out_alu_out;
        MeWb_out_reg_wrt_en <= ExMe_out_reg_wrt_en && !misalign && !expire;
        MeWb_out_result_sel <= ExMe_out_result_sel;
        MeWb_out_rd <= ExMe_out_rd;
        MeWb_out_LR <= ExMe_out_LR;
        MeWb_out_FL <= ExMe_out_FL;
        if (done && !dmem_we) MeWb_out_mem_data <= dmem_rdata;
      end
    end
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage: consumes the EX/MEM register fields, performs at most one word load or store per instruction over a req/ack data-memory handshake, and drives the MEM/WB pipeline register. Variable memory latency is absorbed by a two-state FSM. While an access is outstanding, the FSM raises `mem_stall` to the hazard unit and inserts bubbles into MEM/WB. Non-memory instructions pass through in one cycle.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before abort. Only used with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ExMe_out_alu_out` in 32: ALU result. This is the memory address for loads and stores.
- `ExMe_out_reg_2` in 32: store data.
- `ExMe_out_mem_en` in 1: instruction accesses memory.
- `ExMe_out_mem_wrt` in 1: 1 = store, 0 = load. Only meaningful when `mem_en` = 1.
- `ExMe_out_reg_wrt_en` in 1: register writeback enable.
- `ExMe_out_result_sel` in 2: writeback mux select, passed through.
- `ExMe_out_rd` in 5: destination register.
- `ExMe_out_LR` in 32: link value, passed through.
- `ExMe_out_FL` in 2: flag value, passed through.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word address.
- `dmem_wdata` out 32: write data.
- `dmem_ack` in 1: request complete. For loads, `dmem_rdata` is valid in the ack cycle.
- `dmem_rdata` in 32: load data.
- `mem_stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `mem_misalign` out 1: one-cycle pulse, address bits [1:0] ≠ 0.
- `mem_fault` out 1: one-cycle pulse on timeout abort.
- `MeWb_out_alu_out` out 32: registered.
- `MeWb_out_mem_data` out 32: registered.
- `MeWb_out_reg_wrt_en` out 1: registered.
- `MeWb_out_result_sel` out 2: registered.
- `MeWb_out_rd` out 5: registered.
- `MeWb_out_LR` out 32: registered.
- `MeWb_out_FL` out 2: registered.

## Operation
- A memory op is valid when `mem_op = ExMe_out_mem_en && (ExMe_out_alu_out[1:0] == 2'b00)`.
- FSM state IDLE:
  - If `mem_op`: latch address, `reg_2` and `mem_wrt` into the `dmem_*` registers, then go to ACCESS.
  - Otherwise stay in IDLE.
- FSM state ACCESS:
  - `dmem_req` = 1. Address, data and `we` are held constant.
  - On `dmem_ack`: return to IDLE. MEM/WB captures the EX/MEM fields. For loads, `MeWb_out_mem_data` = `dmem_rdata`.
- Stall equation: `mem_stall = (IDLE && mem_op) || (ACCESS && !dmem_ack)`. This signal is combinational.
- While `mem_stall` = 1, MEM/WB loads a bubble:
  - `reg_wrt_en` = 0.
  - All other MEM/WB fields are held at their previous values.
- Non-mem instruction, or IDLE with no op: MEM/WB captures the EX/MEM fields every cycle. `MeWb_out_mem_data` holds its previous value.
- Misaligned access (`mem_en` && `addr[1:0]` ≠ 0):
  - No request is issued and no stall occurs.
  - `mem_misalign` pulses for one cycle.
  - The instruction retires as a bubble (`reg_wrt_en` = 0).
- Stores retire with whatever `reg_wrt_en` the decoder supplied. Normally this is 0.
- Reset state:
  - FSM in IDLE.
  - All `dmem_*` outputs = 0.
  - `mem_misalign` and `mem_fault` = 0.
  - All `MeWb_out_*` = 0.
- Reset mid-access: `dmem_req` drops asynchronously and the access is discarded. Memory must tolerate an abandoned request.

## Timing
- Non-mem instruction: 1 cycle through the stage.
- Memory access, ack in the first ACCESS cycle: 2 cycles. The cycle breakdown is:
  - Cycle 0: op presented, stall.
  - Cycle 1: request and ack, stall = 0; MEM/WB updated at the end of cycle 1.
- Each additional ack-wait cycle adds 1 cycle of stall.
- `dmem_ack` is ignored outside ACCESS.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after the ack. `dmem_req` is low for exactly one cycle between requests.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES` without ack:
    - `dmem_req` drops and the FSM goes to IDLE.
    - `mem_fault` pulses.
    - `mem_stall` = 0 that cycle.
    - The instruction retires as a bubble (`reg_wrt_en` = 0).
  - An ack in the same cycle as the limit wins: the access completes normally.
- `MEM_TIMEOUT_EN` undefined: ACCESS waits indefinitely and `mem_fault` is tied to 0.

## Structure
- Shared package `mem_pkg` contains:
  - `mem_state_t` enum {IDLE, ACCESS}.
  - Default `TIMEOUT_CYCLES` constant.
  - Result-select encoding constants shared with writeback.
- Sub-module `mem_watchdog` (timeout counter) is instantiated only under `MEM_TIMEOUT_EN`. All other logic is in `memory_stage`.

## Test plan
- ALU instruction, `alu_out=32'h1234`, `rd=3`, `reg_wrt_en=1`:
  - No stall and no `dmem_req`.
  - Next cycle: `MeWb_out_alu_out=32'h1234`, `MeWb_out_rd=3`.
- Load from `addr=32'h100`, ack with `rdata=32'hCAFEF00D` after 3 ACCESS cycles:
  - `mem_stall` high for 4 cycles.
  - `dmem_addr` stable at `32'h100` throughout.
  - Then `MeWb_out_mem_data=32'hCAFEF00D`, `reg_wrt_en=1`.
  - Bubbles (`reg_wrt_en=0`) during the stall.
- Store to `32'h200` with data `32'hA5A5A5A5`, ack in the first ACCESS cycle, immediately followed by a load:
  - `dmem_we=1` with the given data.
  - Stall exactly 1 cycle per op.
  - `dmem_req` low for one cycle between the two requests.
- Load from `addr=32'h102`:
  - `mem_misalign` pulses once.
  - No `dmem_req`, no stall.
  - `MeWb_out_reg_wrt_en=0`.
- `rst_n` asserted while in ACCESS:
  - `dmem_req` and all MeWb outputs are 0 immediately.
  - After release: FSM in IDLE, and a new load completes normally.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, load with no ack:
  - `mem_fault` pulses after 4 ACCESS cycles.
  - `dmem_req` drops, stall releases.
  - `reg_wrt_en=0`.
